// File: rtl/mod_multiplicador_6b.sv
// mod_multiplicador_6b: registered unsigned array multiplier, low WIDTH bits of A*B plus overflow flag.
module mod_multiplicador_6b #(
    parameter int WIDTH = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] M,
    output logic             OF_MUL
);
    logic [2*WIDTH-1:0] p;
    logic [WIDTH:0]     acc;
    logic               carry;
    logic               pp;
    logic               sum;
    logic [WIDTH-1:0]   m_d, m_q;
    logic               of_d, of_q;
    // Each row ripples the shifted running sum with the next AND row; bit 0 of every row is final.
    always_comb begin
        acc = {1'b0, A & {WIDTH{B[0]}}};
        p = '0;
        p[0] = acc[0];
        carry = 1'b0;
        pp = 1'b0;
        sum = 1'b0;
        for (int i = 1; i < WIDTH; i++) begin
            carry = 1'b0;
            for (int j = 0; j < WIDTH; j++) begin
                pp = A[j] & B[i];
                sum = acc[j+1] ^ pp ^ carry;
                carry = (acc[j+1] & pp) | (carry & (acc[j+1] ^ pp));
                acc[j] = sum;
            end
            acc[WIDTH] = carry;
            p[i] = acc[0];
        end
        p[2*WIDTH-1:WIDTH] = acc[WIDTH:1];
    end
    assign m_d  = p[WIDTH-1:0];
    assign of_d = |p[2*WIDTH-1:WIDTH];
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_q  <= '0;
            of_q <= 1'b0;
        end else begin
            m_q  <= m_d;
            of_q <= of_d;
        end
    end
    assign M      = m_q;
    assign OF_MUL = of_q;
endmodule

// File: tb/tb_mod_multiplicador_6b.sv
// tb_mod_multiplicador_6b: directed and exhaustive checks of the registered 6-bit multiplier.
module tb_mod_multiplicador_6b;
    logic       CLK;
    logic       RST;
    logic [5:0] A;
    logic [5:0] B;
    logic [5:0] M;
    logic       OF_MUL;
    int         n_chk;
    int         n_pass;

    mod_multiplicador_6b #(.WIDTH(6)) dut (
        .CLK(CLK),
        .RST(RST),
        .A(A),
        .B(B),
        .M(M),
        .OF_MUL(OF_MUL)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got of=%0b m=%0d, expected of=%0b m=%0d", tag, got[6], got[5:0], exp[6], exp[5:0]);
    endtask

    task automatic step(input logic [5:0] a, input logic [5:0] b, input string tag, input logic of_e, input logic [5:0] m_e);
        A = a;
        B = b;
        @(posedge CLK);
        #1 check(tag, {OF_MUL, M}, {of_e, m_e});
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        RST = 1'b1;
        A = 6'd5;
        B = 6'd7;
        @(posedge CLK);
        #1 check("rst_edge1", {OF_MUL, M}, 7'd0);
        @(posedge CLK);
        #1 check("rst_edge2", {OF_MUL, M}, 7'd0);
        RST = 1'b0;
        step(6'd5, 6'd7, "first_load", 1'b0, 6'd35);
        step(6'd7, 6'd9, "prod63", 1'b0, 6'd63);
        step(6'd0, 6'd63, "zero_a", 1'b0, 6'd0);
        step(6'd63, 6'd0, "zero_b", 1'b0, 6'd0);
        step(6'd8, 6'd8, "prod64", 1'b1, 6'd0);
        step(6'd3, 6'd22, "prod66", 1'b1, 6'd2);
        step(6'd63, 6'd63, "max", 1'b1, 6'd1);
        step(6'd2, 6'd3, "b2b_1", 1'b0, 6'd6);
        step(6'd9, 6'd9, "b2b_2", 1'b1, 6'd17);
        step(6'd1, 6'd1, "b2b_3", 1'b0, 6'd1);
        A = 6'd40;
        B = 6'd1;
        #3 check("hold", {OF_MUL, M}, {1'b0, 6'd1});
        step(6'd10, 6'd10, "load100", 1'b1, 6'd36);
        #4 RST = 1'b1;
        #1 check("async_rst", {OF_MUL, M}, 7'd0);
        #1 RST = 1'b0;
        step(6'd4, 6'd5, "after_rst", 1'b0, 6'd20);
        for (int b = 0; b < 64; b++) begin
            for (int a = 0; a < 64; a++) begin
                step(6'(a), 6'(b), "sweep", (a * b) > 63, 6'((a * b) % 64));
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
